// File: rtl/gpr_sb.sv
// gpr_sb: multi-port general purpose register file with a per-register busy scoreboard; x0 reads as zero.
// Optional feature: define GPR_SB_BYPASS_EN for same-cycle write-to-read forwarding of data and busy clears.
module gpr_sb #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR-1:0]       wr_clr,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_rd,
  output logic [AW:0]          busy_cnt
);

  logic [XLEN-1:0] regs [1:NREG-1];
  logic [NREG-1:1] busy;
  logic [NREG-1:1] busy_nxt;
  logic [AW:0]     cnt_nxt;
  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic [NWR-1:0]  wv;
  logic [AW-1:0]   ra [NRD];

  // Unpack write ports; a write to x0 is never valid.
  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wa[j] = wr_addr[j*AW +: AW];
    assign wd[j] = wr_data[j*XLEN +: XLEN];
    assign wv[j] = wr_en[j] && (wa[j] != '0);
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign ra[i] = rd_addr[i*AW +: AW];
  end

  // Clears apply first so a same-cycle issue to the same register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wv[j] && wr_clr[j]) busy_nxt[wa[j]] = 1'b0;
    end
    if (iss_en && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
    for (int r = 1; r < NREG; r++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
    end
  end

  // Later write ports are evaluated last, so the highest port wins on an address conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++) regs[r] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wv[j]) regs[wa[j]] <= wd[j];
      end
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Combinational read ports.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ra[i] != '0) begin
        rd_data[i*XLEN +: XLEN] = regs[ra[i]];
        rd_busy[i]              = busy[ra[i]];
`ifdef GPR_SB_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (wv[j] && (wa[j] == ra[i])) begin
            rd_data[i*XLEN +: XLEN] = wd[j];
            if (wr_clr[j] && !(iss_en && (iss_rd == ra[i]))) rd_busy[i] = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: doc/gpr_sb.md
# gpr_sb

Parametrised multi-port general purpose register file with an integrated scoreboard, for the pipelined core. It provides NRD combinational read ports and NWR write-back ports, and keeps x0 hardwired to zero. A per-register busy bit is set at issue and cleared at write-back, so the decode stage can detect RAW hazards. It replaces the single-issue register file in the decode/write-back path.

## Interface
- XLEN, 64, data width per register
- NREG, 32, number of registers (power of two, ≥ 2); AW = $clog2(NREG)
- NRD, 2, number of read ports
- NWR, 2, number of write-back ports
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rd_addr  input  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  output  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rd_busy  output  NRD  scoreboard busy bit of each read address
- wr_en  input  NWR  write-back enable per port
- wr_clr  input  NWR  write-back also clears busy bit of wr_addr (valid only with wr_en)
- wr_addr  input  NWR*AW  write-back addresses
- wr_data  input  NWR*XLEN  write-back data
- iss_en  input  1  issue strobe: mark iss_rd busy
- iss_rd  input  AW  destination register of issued instruction
- busy_cnt  output  AW+1  number of registers currently busy

## Operation
- State: NREG-1 registers of XLEN bits (index 1..NREG-1) and NREG-1 busy bits. Register 0 is not stored.
- Reset (rst=1 at a clock edge): all registers are set to 0, all busy bits to 0, and busy_cnt to 0. rd_data and rd_busy then read 0 for every address.
- Read:
  - rd_data[i] = reg[rd_addr[i]], combinational.
  - Address 0 always returns 0 with rd_busy 0.
- Write:
  - On the edge with wr_en[j]=1 and wr_addr[j]≠0, reg[wr_addr[j]] is set to wr_data[j].
  - Writes to address 0 are discarded, including any wr_clr.
- Write conflict: if several ports write the same address in one cycle, the highest-index port wins for data. Busy is cleared if any of those ports asserts wr_clr.
- Issue: iss_en=1 with iss_rd≠0 sets busy[iss_rd] on the edge. Issue to x0 is ignored.
- Issue and clear of the same register in one cycle: issue wins, and busy stays 1. This covers a new producer issuing while the old one writes back.
- wr_clr with wr_en=0 has no effect.
- busy_cnt = population count of the busy bits, registered. It is updated on the same edge as the busy bits and is never negative or greater than NREG-1.

## Timing
- Read latency: 0 cycles (combinational from rd_addr and state).
- Write latency: 1 cycle. Data written at edge N is visible on rd_data after edge N without bypass.
- Issue/clear latency: 1 cycle. The busy bit changes after the edge.
- rst has priority over all writes and issues in the same cycle. A reset asserted mid-operation discards all in-flight writes, issues and clears of that cycle.
- No handshake or backpressure. Callers stall issue externally on rd_busy.

## Configuration
- GPR_SB_BYPASS_EN defined: write-to-read forwarding is enabled.
  - If any wr_en[j] with wr_addr[j]==rd_addr[i]≠0 is active in the current cycle, rd_data[i] returns that wr_data (highest matching j).
  - If any matching port also has wr_clr=1 and there is no same-cycle iss_en to that register, rd_busy[i] returns 0 in that cycle.
- GPR_SB_BYPASS_EN undefined: reads reflect registered state only; same-cycle writes and clears are visible from the next cycle.
- busy_cnt is never bypassed.

## Test plan
- Reset: write 0xDEAD to x5, issue x5, then pulse rst → the next cycle rd_data(x5)=0, rd_busy=0, busy_cnt=0.
- x0 protection: wr_en on x0 with 0xFFFF_FFFF_FFFF_FFFF and iss_rd=0 → rd_data(x0)=0, rd_busy(x0)=0, busy_cnt unchanged.
- Dual write conflict: port0 writes x7=0x11, port1 writes x7=0x22 in the same cycle → the next cycle x7 reads 0x22.
- Scoreboard: issue x3 → busy_cnt=1, rd_busy(x3)=1. In one later cycle, issue x3 while port0 writes x3 with wr_clr → x3 stays busy. Then wr_clr alone → busy_cnt=0.
- Bypass (GPR_SB_BYPASS_EN): port1 writes x9=0xABC with wr_clr while x9 is busy and read port 0 reads x9 → the same cycle rd_data=0xABC and rd_busy=0. Without the macro, the same cycle shows the old value and busy=1, and the next cycle shows 0xABC and busy=0.
- Parameter sweep: NREG=16, NRD=3, NWR=1, XLEN=32. Random issue/write/read traffic is checked against a reference model, including busy_cnt.
